// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg: shared state encoding and constants for mem_ctrl.   Rev 1.0       |
// +----------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    NEXT   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int ZP_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/mem_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_addr_gen: {mar, k, zero_page, mem_part} -> RAM address.  Rev 1.0       |
// +----------------------------------------------------------------------------+
module mem_addr_gen
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PART_W = 1,
  parameter int K_W    = 2
) (
  input  logic [ADDR_W-1:0]        mar,
  input  logic [K_W-1:0]           k,
  input  logic                     zero_page,
  input  logic [PART_W-1:0]        mem_part,
  output logic [PART_W+ADDR_W-1:0] ram_addr
);

  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] eff_addr;

  // Low bits of mar+k equal the page-0 offset sum, so one adder serves both modes.
  always_comb begin
    sum      = mar + ADDR_W'(k);
    eff_addr = sum;
    if (zero_page) begin
      eff_addr = {{(ADDR_W-ZP_BITS){1'b0}}, sum[ZP_BITS-1:0]};
    end
  end

  assign ram_addr = {mem_part, eff_addr};

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_ctrl: MAR/MBR holder sequencing byte/word async-RAM transfers.         |
// | Option MEM_CTRL_AUTOINC_EN: MAR advances by bytes moved at DONE. Rev 1.0   |
// +----------------------------------------------------------------------------+
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WORD_BYTES  = 2,
  parameter int PART_W      = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mar_load,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         mbr_load,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         req,
  input  logic                         we,
  input  logic                         word,
  input  logic                         zero_page,
  input  logic [PART_W-1:0]            mem_part,
  output logic [DATA_W*WORD_BYTES-1:0] data_out,
  output logic                         busy,
  output logic                         done,
  output logic [PART_W+ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic                         ram_we_n,
  output logic                         ram_oe_n
);

  localparam int K_W   = $clog2(WORD_BYTES) + 1;
  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam logic [K_W-1:0] K_LAST    = K_W'(WORD_BYTES - 1);
  localparam logic [3:0]     WAIT_LAST = 4'(WAIT_STATES);

  state_e                               state_q, state_d;
  logic [ADDR_W-1:0]                    mar_q, mar_d;
  logic [WORD_BYTES-1:0][DATA_W-1:0]    mbr_q, mbr_d;
  logic [K_W-1:0]                       k_q, k_d;
  logic [3:0]                           wait_q, wait_d;
  logic                                 we_q, we_d;
  logic                                 word_q, word_d;
  logic                                 zp_q, zp_d;
  logic [PART_W-1:0]                    part_q, part_d;
  logic                                 ram_we_n_q, ram_we_n_d;
  logic                                 ram_oe_n_q, ram_oe_n_d;

  logic [K_W-1:0]                       k_sel;
  logic [IDX_W-1:0]                     k_idx;
  logic [PART_W+ADDR_W-1:0]             ram_addr_w;

  assign k_idx = k_q[IDX_W-1:0];

  // In DONE the shared generator is repurposed to produce the post-access MAR.
`ifdef MEM_CTRL_AUTOINC_EN
  assign k_sel = (state_q == DONE) ? k_q + K_W'(1) : k_q;
`else
  assign k_sel = k_q;
`endif

  mem_addr_gen #(
    .ADDR_W (ADDR_W),
    .PART_W (PART_W),
    .K_W    (K_W)
  ) u_addr_gen (
    .mar       (mar_q),
    .k         (k_sel),
    .zero_page (zp_q),
    .mem_part  (part_q),
    .ram_addr  (ram_addr_w)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    k_d     = k_q;
    wait_d  = wait_q;
    we_d    = we_q;
    word_d  = word_q;
    zp_d    = zp_q;
    part_d  = part_q;

    case (state_q)
      IDLE: begin
        if (mar_load) mar_d = address;
        if (mbr_load) mbr_d[0] = data_in;
        if (req) begin
          we_d    = we;
          word_d  = word;
          zp_d    = zero_page;
          part_d  = mem_part;
          k_d     = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          if (!we_q) mbr_d[k_idx] = ram_rdata;
          state_d = (word_q && (k_q < K_LAST)) ? NEXT : DONE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      NEXT: begin
        k_d     = k_q + K_W'(1);
        state_d = SETUP;
      end
      DONE: begin
`ifdef MEM_CTRL_AUTOINC_EN
        mar_d = ram_addr_w[ADDR_W-1:0];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they never glitch.
    ram_we_n_d = !((state_d == ACCESS) && we_d);
    ram_oe_n_d = !((state_d == ACCESS) && !we_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mar_q      <= '0;
      mbr_q      <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      zp_q       <= 1'b0;
      part_q     <= '0;
      ram_we_n_q <= 1'b1;
      ram_oe_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mbr_q      <= mbr_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      we_q       <= we_d;
      word_q     <= word_d;
      zp_q       <= zp_d;
      part_q     <= part_d;
      ram_we_n_q <= ram_we_n_d;
      ram_oe_n_q <= ram_oe_n_d;
    end
  end

  assign data_out  = mbr_q;
  assign busy      = (state_q == SETUP) || (state_q == ACCESS) || (state_q == NEXT);
  assign done      = (state_q == DONE);
  assign ram_addr  = ram_addr_w;
  assign ram_wdata = mbr_q[k_idx];
  assign ram_we_n  = ram_we_n_q;
  assign ram_oe_n  = ram_oe_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_ctrl: scoreboard bench for mem_ctrl (WAIT_STATES 0 and 3). Rev 1.0  |
// +----------------------------------------------------------------------------+
module tb_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mar_load = 1'b0, mbr_load = 1'b0, req = 1'b0;
  logic        we = 1'b0, word = 1'b0, zero_page = 1'b0;
  logic [0:0]  mem_part = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  data_in = '0;
  logic [15:0] data_out;
  logic        busy, done, ram_we_n, ram_oe_n;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  logic        b_mar_load = 1'b0, b_req = 1'b0;
  logic [15:0] b_address = '0;
  logic [15:0] b_data_out;
  logic        b_busy, b_done, b_we_n, b_oe_n;
  logic [16:0] b_ram_addr;
  logic [7:0]  b_wdata, b_rdata;

  mem_ctrl #(.ADDR_W(16), .DATA_W(8), .WORD_BYTES(2), .PART_W(1), .WAIT_STATES(0)) u_dut (
    .clk(clk), .rst(rst), .mar_load(mar_load), .address(address), .mbr_load(mbr_load),
    .data_in(data_in), .req(req), .we(we), .word(word), .zero_page(zero_page),
    .mem_part(mem_part), .data_out(data_out), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n));

  mem_ctrl #(.ADDR_W(16), .DATA_W(8), .WORD_BYTES(2), .PART_W(1), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .rst(rst), .mar_load(b_mar_load), .address(b_address), .mbr_load(1'b0),
    .data_in(8'h00), .req(b_req), .we(1'b0), .word(1'b0), .zero_page(1'b0),
    .mem_part(1'b0), .data_out(b_data_out), .busy(b_busy), .done(b_done),
    .ram_addr(b_ram_addr), .ram_wdata(b_wdata), .ram_rdata(b_rdata),
    .ram_we_n(b_we_n), .ram_oe_n(b_oe_n));

  // RAM model for the main DUT; preloads share the single write process.
  logic [7:0]  ram0 [0:131071];
  logic        pl_we = 1'b0;
  logic [16:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  assign ram_rdata = ram0[ram_addr];
  always @(posedge clk) begin
    if (pl_we) ram0[pl_addr] <= pl_data;
    else if (!ram_we_n) ram0[ram_addr] <= ram_wdata;
  end
  assign b_rdata = (b_ram_addr == 17'h00010) ? 8'h5C : 8'hEE;

  typedef struct {
    string       tag;
    bit          is_ram;
    logic [16:0] addr;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_read(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag; e.is_ram = 1'b0; e.addr = '0; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_ram(input string tag, input logic [16:0] a, input logic [7:0] exp);
    sb_t e;
    e.tag = tag; e.is_ram = 1'b1; e.addr = a; e.exp = {8'h00, exp};
    sb_q.push_back(e);
  endtask

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // One transfer on the main DUT; hold_mar keeps a bogus mar_load asserted
  // through busy and the DONE cycle, which must be ignored.
  task automatic access(input string tag, input logic i_we, input logic i_word,
                        input logic i_zp, input logic i_part, input logic ld_mar,
                        input logic [15:0] addr, input logic ld_mbr, input logic [7:0] d0,
                        input int exp_lat, input logic hold_mar);
    int  cyc;
    int  both_low;
    sb_t e;
    both_low = 0;
    @(negedge clk);
    mar_load = ld_mar; address = addr; mbr_load = ld_mbr; data_in = d0;
    req = 1'b1; we = i_we; word = i_word; zero_page = i_zp; mem_part = i_part;
    @(negedge clk);
    req = 1'b0; mbr_load = 1'b0; mar_load = hold_mar;
    if (hold_mar) address = 16'h5555;
    cyc = 1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!done && cyc < 200) begin
      if (!ram_we_n && !ram_oe_n) both_low++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_ram) check(e.tag, {24'd0, ram0[e.addr]}, {16'd0, e.exp});
      else          check(e.tag, {16'd0, data_out}, {16'd0, e.exp});
    end
    @(negedge clk);
    mar_load = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_strobe_excl"}, both_low, 0);
  endtask

  initial begin
    int cyc;
    int oe_cnt;
    int done_seen;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we_n", {31'd0, ram_we_n}, 32'd1);
    check("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
    check("rst_ram_addr", {15'd0, ram_addr}, 32'd0);
    rst = 1'b0;

    // Byte write with MAR/MBR loaded in the req cycle, then read back
    push_ram("wr_byte_ram", 17'h01234, 8'hA5);
    access("wr_byte", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 8'hA5, 3, 1'b0);
    push_read("rd_byte_data", 16'h00A5);
    access("rd_byte", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h00, 3, 1'b0);

    // Word read wrapping across 0xFFFF
    preload(17'h0FFFF, 8'h34);
    preload(17'h00000, 8'h12);
    push_read("rd_wrap_data", 16'h1234);
    access("rd_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 8'h00, 6, 1'b0);

    // Byte read leaves upper byte alone
    preload(17'h00042, 8'h77);
    push_read("rd_keep_hi", 16'h1277);
    access("rd_keep", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 8'h00, 3, 1'b0);

    // Zero page word read wraps 0x00FF -> 0x0000
    preload(17'h000FF, 8'hCD);
    preload(17'h00000, 8'hAB);
    preload(17'h012FF, 8'h11);
    preload(17'h01300, 8'hEE);
    push_read("zp_data", 16'hABCD);
    access("zp", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h12FF, 1'b0, 8'h00, 6, 1'b0);

    // Partition select lands in the upper bank only
    preload(17'h00005, 8'h99);
    push_ram("part_hi_ram", 17'h10005, 8'h3C);
    push_ram("part_lo_ram", 17'h00005, 8'h99);
    access("part", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 8'h3C, 3, 1'b0);

    // Word write, little-endian (MBR = {AB, 5A})
    push_ram("wr_word_b0", 17'h02000, 8'h5A);
    push_ram("wr_word_b1", 17'h02001, 8'hAB);
    access("wr_word", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2000, 1'b1, 8'h5A, 6, 1'b0);

    // MAR post-access behaviour; bogus mar_load held through busy/DONE
    preload(17'h00100, 8'h01);
    preload(17'h00101, 8'h02);
    preload(17'h00102, 8'h33);
    preload(17'h05555, 8'h99);
    push_read("inc_word_data", 16'h0201);
    access("inc_word", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 8'h00, 6, 1'b1);
`ifdef MEM_CTRL_AUTOINC_EN
    push_read("inc_next_data", 16'h0233);
`else
    push_read("inc_next_data", 16'h0201);
`endif
    access("inc_next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 3, 1'b0);

    // Reset in the middle of a word write, after byte 0 was written
    preload(17'h03000, 8'h00);
    preload(17'h03001, 8'h00);
    @(negedge clk);
    mar_load = 1'b1; address = 16'h3000; mbr_load = 1'b1; data_in = 8'h66;
    req = 1'b1; we = 1'b1; word = 1'b1; zero_page = 1'b0; mem_part = 1'b0;
    @(negedge clk);
    mar_load = 1'b0; mbr_load = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_we_n", {31'd0, ram_we_n}, 32'd1);
    check("mid_rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mbr", {16'd0, data_out}, 32'd0);
    rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("mid_rst_no_done", done_seen, 0);
    check("mid_rst_b0", {24'd0, ram0[17'h03000]}, 32'h66);
    check("mid_rst_b1", {24'd0, ram0[17'h03001]}, 32'h00);

    // WAIT_STATES=3 byte read on the second instance
    @(negedge clk);
    b_mar_load = 1'b1; b_address = 16'h0010; b_req = 1'b1;
    @(negedge clk);
    b_mar_load = 1'b0; b_req = 1'b0;
    cyc = 1;
    oe_cnt = 0;
    while (!b_done && cyc < 200) begin
      if (!b_oe_n) oe_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("ws3_latency", cyc, 6);
    check("ws3_oe_cycles", oe_cnt, 4);
    check("ws3_we_n", {31'd0, b_we_n}, 32'd1);
    check("ws3_data", {16'd0, b_data_out}, 32'h005C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
